// File: rtl/gpio_in_conditioner.sv
// ============================================================================
// Module      : gpio_in_conditioner
// Description : Pad synchronizer, per-pin debouncer, edge detector and sticky
//               edge-interrupt pending register for the GPIO input path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpio_in_conditioner #(
    parameter int NUM_PINS  = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PINS-1:0]  gpio_in_i,
    input  logic [CNT_WIDTH-1:0] debounce_cfg_i,
    input  logic [NUM_PINS-1:0]  irq_rise_en_i,
    input  logic [NUM_PINS-1:0]  irq_fall_en_i,
    input  logic [NUM_PINS-1:0]  irq_clr_i,
    output logic [NUM_PINS-1:0]  gpio_db_o,
    output logic [NUM_PINS-1:0]  rise_o,
    output logic [NUM_PINS-1:0]  fall_o,
    output logic [NUM_PINS-1:0]  irq_pending_o,
    output logic                 irq_o
);

    logic [NUM_PINS-1:0] r_sync1;
    logic [NUM_PINS-1:0] r_sync2;
    logic [NUM_PINS-1:0] r_pending;
    logic [NUM_PINS-1:0] w_db;
    logic [NUM_PINS-1:0] w_rise;
    logic [NUM_PINS-1:0] w_fall;
    logic [NUM_PINS-1:0] w_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= gpio_in_i;
            r_sync2 <= r_sync1;
        end
    end

    // Each pin owns its counter and output flops so pins stay fully independent.
    for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin
        logic [CNT_WIDTH-1:0] r_cnt;
        logic                 r_db;
        logic                 r_rise;
        logic                 r_fall;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt  <= '0;
                r_db   <= 1'b0;
                r_rise <= 1'b0;
                r_fall <= 1'b0;
            end else begin
                r_rise <= 1'b0;
                r_fall <= 1'b0;
                if (r_sync2[i] == r_db) begin
                    r_cnt <= '0;
                end else if (r_cnt >= debounce_cfg_i) begin
                    // >= lets a lowered window take effect on the very next cycle
                    r_db   <= r_sync2[i];
                    r_cnt  <= '0;
                    r_rise <= r_sync2[i];
                    r_fall <= ~r_sync2[i];
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign w_db[i]   = r_db;
        assign w_rise[i] = r_rise;
        assign w_fall[i] = r_fall;
    end

    assign w_set = (w_rise & irq_rise_en_i) | (w_fall & irq_fall_en_i);

    // Set is OR-ed in after the clear so a colliding new edge is never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~irq_clr_i) | w_set;
        end
    end

    assign gpio_db_o     = w_db;
    assign rise_o        = w_rise;
    assign fall_o        = w_fall;
    assign irq_pending_o = r_pending;
    assign irq_o         = |r_pending;

endmodule

`default_nettype wire

// File: tb/tb_gpio_in_conditioner.sv
// ============================================================================
// Module      : tb_gpio_in_conditioner
// Description : Directed and randomized bench for gpio_in_conditioner against
//               a run-length reference model of the debounce rules.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gpio_in_conditioner;

    localparam int NP = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [NP-1:0] gpio_in;
    logic [CW-1:0] cfg;
    logic [NP-1:0] ren, fen, clr;
    logic [NP-1:0] db, rise, fall, pend;
    logic          irq;

    int n_tests = 0;
    int n_fail  = 0;

    gpio_in_conditioner #(.NUM_PINS(NP), .CNT_WIDTH(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .gpio_in_i      (gpio_in),
        .debounce_cfg_i (cfg),
        .irq_rise_en_i  (ren),
        .irq_fall_en_i  (fen),
        .irq_clr_i      (clr),
        .gpio_db_o      (db),
        .rise_o         (rise),
        .fall_o         (fall),
        .irq_pending_o  (pend),
        .irq_o          (irq)
    );

    always #5 clk = ~clk;

    // Reference: a change is accepted once sync2 has shown the same new value
    // for cfg+1 consecutive samples.
    logic [NP-1:0] m_s1 = '0, m_s2 = '0, m_last = '0;
    logic [NP-1:0] m_db = '0, m_rise = '0, m_fall = '0, m_pend = '0;
    logic [NP-1:0] m_acc;
    int            run [NP];

    initial for (int i = 0; i < NP; i++) run[i] = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_last = '0;
            m_db = '0; m_rise = '0; m_fall = '0; m_pend = '0;
            for (int i = 0; i < NP; i++) run[i] = 0;
        end else begin
            for (int i = 0; i < NP; i++) begin
                if (run[i] > 0 && m_s2[i] == m_last[i]) run[i] = run[i] + 1;
                else run[i] = 1;
                m_last[i] = m_s2[i];
                m_acc[i]  = (m_s2[i] != m_db[i]) && (run[i] >= int'(cfg) + 1);
            end
            m_pend = (m_pend & ~clr) | (m_rise & ren) | (m_fall & fen);
            m_rise = m_acc & m_s2;
            m_fall = m_acc & ~m_s2;
            m_db   = m_db ^ m_acc;
            m_s2   = m_s1;
            m_s1   = gpio_in;
        end
    end

    task automatic check(input string tag, input logic [NP-1:0] obs, input logic [NP-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        check("db",   db,   m_db);
        check("rise", rise, m_rise);
        check("fall", fall, m_fall);
        check("pend", pend, m_pend);
        check("irq",  {{(NP-1){1'b0}}, irq}, {{(NP-1){1'b0}}, |m_pend});
    endtask

    initial begin
        rst = 1'b1; gpio_in = '0; cfg = '0; ren = '0; fen = '0; clr = '0;
        repeat (2) step();
        check("reset_db", db, '0);

        // basic propagation, cfg=0
        ren = 32'h10; rst = 1'b0; step();
        gpio_in[4] = 1'b1;
        repeat (3) step();
        check("basic_db",   db & 32'h10, 32'h10);
        check("basic_rise", rise, 32'h10);
        step();
        check("basic_pend", pend, 32'h10);
        check("basic_irq",  {31'b0, irq}, 32'h1);
        clr = 32'h10; step(); clr = '0;
        check("clr_pend", pend, '0);
        check("clr_irq",  {31'b0, irq}, 32'h0);

        // glitch filter, cfg=4
        gpio_in[4] = 1'b0; repeat (4) step();
        cfg = 4; gpio_in[4] = 1'b1; repeat (4) step();
        gpio_in[4] = 1'b0; repeat (10) step();
        check("glitch_db", db & 32'h10, '0);
        gpio_in[4] = 1'b1; repeat (6) step();
        check("hold_early", rise, '0);
        step();
        check("hold_rise", rise, 32'h10);
        step();
        check("hold_once", rise, '0);

        // fall-only enable
        ren = '0; fen = 32'h10; cfg = 0; clr = '1; step(); clr = '0;
        gpio_in[4] = 1'b0; repeat (4) step();
        check("fall_pend", pend, 32'h10);
        gpio_in[4] = 1'b1; repeat (4) step();

        // set/clear collision
        ren = 32'h10; fen = '0; clr = '1; step(); clr = '0;
        gpio_in[4] = 1'b0; repeat (4) step();
        gpio_in[4] = 1'b1; repeat (3) step();
        clr = 32'h10; step(); clr = '0;
        check("collision", pend & 32'h10, 32'h10);

        // window lowered mid-count
        cfg = 100; gpio_in[7] = 1'b1; repeat (22) step();
        check("cfg_wait", rise, '0);
        cfg = 10; step();
        check("cfg_accept", rise, 32'h80);
        step();
        check("cfg_single", rise, '0);

        // pins high through reset
        gpio_in = 32'h8000_0001; cfg = 2; ren = '1; rst = 1'b1; repeat (2) step();
        rst = 1'b0;
        repeat (4) step();
        check("post_rst_early", rise, '0);
        step();
        check("post_rst_rise", rise, 32'h8000_0001);

        // reset mid-count
        cfg = 20; gpio_in = 32'h0F0F_0000; repeat (8) step();
        rst = 1'b1; step();
        check("midrst_db",   db,   '0);
        check("midrst_rise", rise, '0);
        rst = 1'b0;

        // randomized traffic
        cfg = 3;
        for (int n = 0; n < 4000; n++) begin
            gpio_in ^= $urandom & $urandom & $urandom;
            if ($urandom_range(0, 63) == 0) cfg = CW'($urandom_range(0, 6));
            if ((n % 100) == 0) begin
                ren = $urandom;
                fen = $urandom;
            end
            clr = ($urandom_range(0, 7) == 0) ? NP'($urandom) : '0;
            rst = ($urandom_range(0, 499) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/gpio_in_conditioner.md
Name: gpio_in_conditioner

Overview:
- Input-conditioning stage directly upstream of the GPIO peripheral's gpio_in port. Synchronizes the asynchronous pad inputs and debounces each pin with a programmable stability window.
- Per pin, detects rising and falling edges on the debounced level and latches enabled edges into a sticky pending register that drives one combined interrupt line.
- Bench stimulus on gpio_in (for example, toggling pin 4) passes through this block before the core sees it.

Parameters:
- NUM_PINS, 32: number of GPIO input pins conditioned.
- CNT_WIDTH, 16: width of each per-pin debounce counter and of debounce_cfg_i.

Ports:
- clk  input  1  system clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- gpio_in_i  input  NUM_PINS  raw pad inputs, asynchronous to clk.
- debounce_cfg_i  input  CNT_WIDTH  a change is accepted after debounce_cfg_i+1 consecutive stable cycles.
- irq_rise_en_i  input  NUM_PINS  per-pin enable for latching rising edges into pending.
- irq_fall_en_i  input  NUM_PINS  per-pin enable for latching falling edges into pending.
- irq_clr_i  input  NUM_PINS  write-1-to-clear strobe for pending bits, sampled every cycle.
- gpio_db_o  output  NUM_PINS  debounced, synchronized level to the GPIO peripheral.
- rise_o  output  NUM_PINS  one-cycle pulse on an accepted 0->1 change.
- fall_o  output  NUM_PINS  one-cycle pulse on an accepted 1->0 change.
- irq_pending_o  output  NUM_PINS  sticky pending edge flags.
- irq_o  output  1  OR-reduction of irq_pending_o.

Behaviour:
- Clock and reset: single clock; reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: all of the following are 0 — sync flops, counters, gpio_db_o, rise_o, fall_o, irq_pending_o, irq_o.
- Synchronizer:
  - Two-flop synchronizer per pin: sync1 <= gpio_in_i; sync2 <= sync1.
  - sync2 is the only internal use of the pad value.
- Per-pin debounce (all pins independent):
  - If sync2 == gpio_db_o[i]: cnt[i] <= 0.
  - Else if cnt[i] >= debounce_cfg_i: gpio_db_o[i] <= sync2; cnt[i] <= 0; pulse rise_o[i] or fall_o[i] per direction.
  - Else: cnt[i] <= cnt[i] + 1.
  - Comparison uses >=, so lowering debounce_cfg_i mid-count causes acceptance on the next cycle. The counter never wraps.
- Latency:
  - A pad change held long enough appears on gpio_db_o exactly debounce_cfg_i+3 clk edges after the first edge that samples it into sync1.
  - This is 3 cycles for cfg=0.
- Glitch rejection:
  - A difference lasting <= debounce_cfg_i cycles at sync2 produces no change on gpio_db_o and no edge pulse.
  - The counter restarts from 0 on any return to the debounced level.
- Edge pulses: rise_o and fall_o are registered and asserted in the same cycle gpio_db_o first shows the new value, for exactly 1 cycle.
- Pending register, per bit:
  - set = (rise_o & irq_rise_en_i) | (fall_o & irq_fall_en_i), evaluated on the registered pulses.
  - Pending is updated one cycle after the pulse.
  - pending <= (pending & ~irq_clr_i) | set.
  - Simultaneous set and clear on the same bit: set wins and the bit stays 1.
  - Enables gate only new sets. Disabling an enable does not clear an already pending bit.
- irq_o: combinational OR of the pending flops, with no extra latency relative to irq_pending_o.
- Post-reset: a pin already high at reset release is treated as a 0->1 change. It produces rise_o after debounce_cfg_i+3 cycles and, if enabled, a pending bit.
- Reset mid-operation: an in-progress count is discarded and gpio_db_o returns to 0 in the cycle after rst is sampled high.
- Simultaneous multi-pin changes are handled independently. Several pending bits may set in the same cycle.

Test Plan:
- Basic propagation: cfg=0, rst released, pin 4 driven 0->1 → gpio_db_o[4]=1 and rise_o[4] pulse on the 3rd edge; with irq_rise_en_i[4]=1, irq_pending_o=32'h10 and irq_o=1 one cycle later.
- Glitch filter: cfg=4, pin 4 high for 4 cycles then low → gpio_db_o[4] stays 0, no pulse. Held high for 5 cycles → accepted 7 edges after first sample, rise_o[4] for exactly 1 cycle.
- Edge enables and clear:
  - rise_en=0, fall_en[4]=1, pin 4 toggles 0->1->0 → only the falling edge sets pending bit 4.
  - irq_clr_i=32'h10 for 1 cycle → irq_pending_o=0 and irq_o=0 next cycle.
- Set/clear collision: irq_clr_i[4] asserted in the same cycle a new enabled rise sets bit 4 → irq_pending_o[4] remains 1.
- Config change mid-count: cfg=100, pin 7 changes, after 20 stable cycles cfg is written 10 → accepted on the next cycle, with a single rise_o[7].
- Reset behaviour:
  - Pins 0 and 31 high through reset, cfg=2 → rise_o=32'h8000_0001 pulse 5 cycles after release.
  - Reset asserted mid-count → all outputs 0 the following cycle, with no spurious pulse.
